// File: rtl/mem_if_pkg.sv
// Shared types and constants for the data-memory load/store interface.
// Combinational definitions only; no latency or backpressure of its own.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1001_0000;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: store byte enables/replication, load extract/extend.
// Purely combinational (zero latency); no handshake, no backpressure.
module lsu_lane_align
  import mem_if_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    byte_en   = 4'b0000;
    misalign  = 1'b0;
    rdata_ext = '0;
    wdata_rep = wdata;
    // Bring the addressed lane down to bit 0 before extension.
    shifted   = raw_word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        misalign  = lane[0];
        byte_en   = 4'b0011 << lane;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        misalign  = (lane != 2'd0);
        byte_en   = 4'b1111;
        rdata_ext = raw_word;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data-memory slave: one request at a time, WAIT_STATES+2 cycles to rsp_valid_o.
// req_ready_o stays low from accept until the response is taken; response held until rsp_ready_i.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 256,
  parameter int          WAIT_STATES  = 2,
  parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_error_o
);

  localparam int          AW          = $clog2(MEMORY_DEPTH);
  localparam logic [3:0]  WAIT_LAST   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [31:0] RANGE_BYTES = 32'(MEMORY_DEPTH * 4);

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  write_q;
  logic                  uns_q;
  logic                  range_err_q;
  logic [1:0]            size_q;
  logic [1:0]            lane_q;
  logic [AW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic [31:0]           req_offset;
  logic [3:0]            byte_en;
  logic [31:0]           wdata_rep;
  logic [31:0]           rdata_ext;
  logic                  misalign;
  logic                  access_err;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range check.
  assign req_offset = req_addr_i - BASE_ADDR;
  assign access_err = range_err_q | misalign;

  lsu_lane_align u_align (
    .size        (size_q),
    .lane        (lane_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .raw_word    (mem[idx_q]),
    .byte_en     (byte_en),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            write_q     <= req_write_i;
            uns_q       <= req_unsigned_i;
            size_q      <= req_size_i;
            lane_q      <= req_offset[1:0];
            idx_q       <= req_offset[AW+1:2];
            wdata_q     <= req_wdata_i;
            range_err_q <= (req_offset >= RANGE_BYTES);
            wait_cnt    <= 4'd0;
            req_ready_o <= 1'b0;
            state       <= (WAIT_STATES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (wait_cnt == WAIT_LAST) state <= ACCESS;
        end
        ACCESS: begin
          rsp_error_o <= access_err;
          rsp_rdata_o <= (access_err || write_q) ? '0 : rdata_ext;
          state       <= RESP;
        end
        RESP: begin
          // First RESP cycle raises valid; afterwards wait for the initiator.
          if (!rsp_valid_o) begin
            rsp_valid_o <= 1'b1;
          end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Commit happens only on the ACCESS edge, so a reset before it drops the store.
  always_ff @(posedge clk) begin
    if (reset && state == ACCESS && write_q && !access_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx_q][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: two instances (WAIT_STATES 0 and 2) vs a byte-array model.
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_error [2];

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mdl [2][1024];
  int         win [20];

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_error_o(rsp_error[0])
  );

  data_mem_responder #(.WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_error_o(rsp_error[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory as a flat byte array; an access covers 2**size bytes and must be naturally aligned.
  task automatic model(input int sel, input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd, output logic [31:0] d, output logic e);
    logic [31:0] off;
    logic [31:0] tmp;
    int n;
    off = addr - BASE;
    n   = 1 << sz;
    e   = (sz == 2'd3) || ((off % n) != 0) || (off >= 32'd1024);
    d   = '0;
    if (!e) begin
      if (wr) begin
        for (int i = 0; i < n; i++) begin
          tmp = wd >> (8 * i);
          mdl[sel][int'(off) + i] = tmp[7:0];
        end
      end else begin
        for (int i = 0; i < n; i++) d = d | (32'(mdl[sel][int'(off) + i]) << (8 * i));
        if (!uns && n < 4 && d[8*n-1]) d = d | ~((32'd1 << (8 * n)) - 32'd1);
      end
    end
  endtask

  task automatic scramble();
    req_write    = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
  endtask

  task automatic txn(input int sel, input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] wd, input int hold,
                     input logic use_exp, input logic [31:0] xd, input logic xe);
    logic [31:0] md;
    logic [31:0] d0;
    logic        me;
    logic        e0;
    int          lat;
    model(sel, wr, addr, sz, uns, wd, md, me);
    if (use_exp) begin
      md = xd;
      me = xe;
    end
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[sel]), 32'd1);
    req_write = wr; req_addr = addr; req_size = sz; req_unsigned = uns; req_wdata = wd;
    req_valid[sel] = 1'b1;
    rsp_ready[sel] = 1'b0;
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    scramble();
    chk("req_ready_busy", 32'(req_ready[sel]), 32'd0);
    lat = 0;
    while (rsp_valid[sel] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), (sel == 1) ? 32'd4 : 32'd2);
    chk("rdata", rsp_rdata[sel], md);
    chk("error", 32'(rsp_error[sel]), 32'(me));
    d0 = rsp_rdata[sel];
    e0 = rsp_error[sel];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_valid[sel] = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid[sel]), 32'd1);
      chk("hold_rdata", rsp_rdata[sel], d0);
      chk("hold_error", 32'(rsp_error[sel]), 32'(e0));
      chk("hold_req_ready", 32'(req_ready[sel]), 32'd0);
    end
    @(negedge clk);
    req_valid[sel] = 1'b0;
    rsp_ready[sel] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[sel] = 1'b0;
    chk("valid_after_hs", 32'(rsp_valid[sel]), 32'd0);
    chk("ready_after_hs", 32'(req_ready[sel]), 32'd1);
  endtask

  task automatic check_reset_outputs();
    for (int s = 0; s < 2; s++) begin
      chk("rst_req_ready", 32'(req_ready[s]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[s], 32'd0);
      chk("rst_rsp_error", 32'(rsp_error[s]), 32'd0);
    end
  endtask

  // Store accepted, then reset on the very next edge: before any commit for either wait setting.
  task automatic abort_store(input int sel, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    chk("abort_ready", 32'(req_ready[sel]), 32'd1);
    req_write = 1'b1; req_addr = addr; req_size = 2'd2; req_unsigned = 1'b0; req_wdata = wd;
    req_valid[sel] = 1'b1;
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          sel;
    reset     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    scramble();
    for (int i = 0; i < 16; i++) win[i] = i;
    for (int i = 0; i < 4; i++) win[16 + i] = 252 + i;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 20; w++)
        txn(s, 1'b1, BASE + 32'(win[w] * 4), 2'd2, 1'b0, $urandom, 0, 1'b0, '0, 1'b0);

    txn(1, 1'b1, 32'h1001_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, 1'b1, 32'h0000_0000, 1'b0);
    txn(1, 1'b0, 32'h1001_0004, 2'd2, 1'b0, 32'h0,         0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    txn(1, 1'b0, 32'h1001_0007, 2'd0, 1'b0, 32'h0,         0, 1'b1, 32'hFFFF_FFDE, 1'b0);
    txn(1, 1'b0, 32'h1001_0004, 2'd1, 1'b1, 32'h0,         0, 1'b1, 32'h0000_BEEF, 1'b0);
    txn(1, 1'b1, 32'h1001_0005, 2'd0, 1'b0, 32'hABCD_127A, 0, 1'b1, 32'h0000_0000, 1'b0);
    txn(1, 1'b0, 32'h1001_0004, 2'd2, 1'b0, 32'h0,         0, 1'b1, 32'hDEAD_7AEF, 1'b0);
    txn(1, 1'b0, 32'h1001_0002, 2'd2, 1'b0, 32'h0,         5, 1'b1, 32'h0000_0000, 1'b1);
    txn(1, 1'b0, 32'h1001_0400, 2'd2, 1'b0, 32'h0,         0, 1'b1, 32'h0000_0000, 1'b1);
    txn(1, 1'b1, 32'h1000_FFFC, 2'd2, 1'b0, 32'h1234_5678, 0, 1'b1, 32'h0000_0000, 1'b1);
    txn(1, 1'b0, 32'h1001_03FC, 2'd2, 1'b0, 32'h0,         0, 1'b0, '0, 1'b0);
    txn(1, 1'b0, 32'h1001_0000, 2'd2, 1'b0, 32'h0,         0, 1'b0, '0, 1'b0);

    abort_store(1, 32'h1001_0008, 32'h55AA_55AA);
    txn(1, 1'b0, 32'h1001_0008, 2'd2, 1'b0, 32'h0, 0, 1'b0, '0, 1'b0);
    abort_store(0, 32'h1001_0008, 32'h55AA_55AA);
    txn(0, 1'b0, 32'h1001_0008, 2'd2, 1'b0, 32'h0, 0, 1'b0, '0, 1'b0);

    for (int t = 0; t < 200; t++) begin
      sel = t % 2;
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 11))
        0:       a = BASE + 32'd1024 + 32'($urandom_range(0, 4095));
        1:       a = BASE - 32'($urandom_range(1, 64));
        default: a = BASE + 32'(win[$urandom_range(0, 19)] * 4) + 32'($urandom_range(0, 3));
      endcase
      txn(sel, 1'($urandom), a, sz, 1'($urandom), $urandom, $urandom_range(0, 2), 1'b0, '0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
